// File: rtl/cell_hist_accum_pkg.sv
// rtl/cell_hist_accum_pkg.sv - shared constants for the cell histogram accumulator
package cell_hist_accum_pkg;

    localparam int NUM_BINS  = 9;
    localparam int FRAC_BITS = 16;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage

// File: rtl/cell_hist_accum_sat_add.sv
// rtl/cell_hist_accum_sat_add.sv - unsigned saturating adder with overflow flag
module sat_add #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_sat
);

    logic [W:0] w_raw;

    assign w_raw = {1'b0, i_a} + {1'b0, i_b};
    assign o_sat = w_raw[W];
    assign o_sum = w_raw[W] ? {W{1'b1}} : w_raw[W-1:0];

endmodule

// File: rtl/cell_hist_accum.sv
// rtl/cell_hist_accum.sv - sums CELL_PIXELS nine-bin votes into one buffered cell histogram
module cell_hist_accum
    import cell_hist_accum_pkg::*;
#(
    parameter int CELL_PIXELS = 64,
    parameter int BIN_W       = 32
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [BIN_W-1:0] iBin1,
    input  logic [BIN_W-1:0] iBin2,
    input  logic [BIN_W-1:0] iBin3,
    input  logic [BIN_W-1:0] iBin4,
    input  logic [BIN_W-1:0] iBin5,
    input  logic [BIN_W-1:0] iBin6,
    input  logic [BIN_W-1:0] iBin7,
    input  logic [BIN_W-1:0] iBin8,
    input  logic [BIN_W-1:0] iBin9,
    output logic             oValid,
    input  logic             iReady,
    output logic [BIN_W-1:0] oBin1,
    output logic [BIN_W-1:0] oBin2,
    output logic [BIN_W-1:0] oBin3,
    output logic [BIN_W-1:0] oBin4,
    output logic [BIN_W-1:0] oBin5,
    output logic [BIN_W-1:0] oBin6,
    output logic [BIN_W-1:0] oBin7,
    output logic [BIN_W-1:0] oBin8,
    output logic [BIN_W-1:0] oBin9,
    output logic             oSat
);

    localparam int                CNT_W    = $clog2(CELL_PIXELS);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CELL_PIXELS - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat_flag;
    logic             r_ovalid;
    logic             r_osat;
    logic [BIN_W-1:0] r_acc  [NUM_BINS];
    logic [BIN_W-1:0] r_obuf [NUM_BINS];

    logic [BIN_W-1:0]    w_in  [NUM_BINS];
    logic [BIN_W-1:0]    w_sum [NUM_BINS];
    logic [NUM_BINS-1:0] w_bin_sat;
    logic                w_any_sat;
    logic                w_accept;
    logic                w_last;
    logic                w_drain;
    logic                w_buf_free;

    assign w_in[0] = iBin1;
    assign w_in[1] = iBin2;
    assign w_in[2] = iBin3;
    assign w_in[3] = iBin4;
    assign w_in[4] = iBin5;
    assign w_in[5] = iBin6;
    assign w_in[6] = iBin7;
    assign w_in[7] = iBin8;
    assign w_in[8] = iBin9;

    for (genvar g = 0; g < NUM_BINS; g++) begin : g_add
        sat_add #(.W(BIN_W)) u_sat_add (
            .i_a   (r_acc[g]),
            .i_b   (w_in[g]),
            .o_sum (w_sum[g]),
            .o_sat (w_bin_sat[g])
        );
    end

    assign w_any_sat  = |w_bin_sat;
    assign oReady     = (r_state == ST_ACCUM);
    assign w_accept   = iValid && oReady;
    assign w_last     = w_accept && (r_cnt == LAST_CNT);
    assign w_drain    = r_ovalid && iReady;
    assign w_buf_free = !r_ovalid || iReady;

    // Later assignments in this block override the drain clear when a new cell loads on the same edge.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state    <= ST_ACCUM;
            r_cnt      <= '0;
            r_sat_flag <= 1'b0;
            r_ovalid   <= 1'b0;
            r_osat     <= 1'b0;
            for (int k = 0; k < NUM_BINS; k++) begin
                r_acc[k]  <= '0;
                r_obuf[k] <= '0;
            end
        end else begin
            if (w_drain) begin
                r_ovalid <= 1'b0;
            end
            if (r_state == ST_HOLD) begin
                if (iReady) begin
                    for (int k = 0; k < NUM_BINS; k++) begin
                        r_obuf[k] <= r_acc[k];
                        r_acc[k]  <= '0;
                    end
                    r_osat     <= r_sat_flag;
                    r_ovalid   <= 1'b1;
                    r_sat_flag <= 1'b0;
                    r_state    <= ST_ACCUM;
                end
            end else if (w_accept) begin
                if (w_last) begin
                    r_cnt <= '0;
                    if (w_buf_free) begin
                        for (int k = 0; k < NUM_BINS; k++) begin
                            r_obuf[k] <= w_sum[k];
                            r_acc[k]  <= '0;
                        end
                        r_osat     <= r_sat_flag || w_any_sat;
                        r_ovalid   <= 1'b1;
                        r_sat_flag <= 1'b0;
                    end else begin
                        // Finished cell parks in the accumulators until the consumer frees the buffer.
                        for (int k = 0; k < NUM_BINS; k++) begin
                            r_acc[k] <= w_sum[k];
                        end
                        r_sat_flag <= r_sat_flag || w_any_sat;
                        r_state    <= ST_HOLD;
                    end
                end else begin
                    for (int k = 0; k < NUM_BINS; k++) begin
                        r_acc[k] <= w_sum[k];
                    end
                    r_sat_flag <= r_sat_flag || w_any_sat;
                    r_cnt      <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign oValid = r_ovalid;
    assign oSat   = r_osat;
    assign oBin1  = r_obuf[0];
    assign oBin2  = r_obuf[1];
    assign oBin3  = r_obuf[2];
    assign oBin4  = r_obuf[3];
    assign oBin5  = r_obuf[4];
    assign oBin6  = r_obuf[5];
    assign oBin7  = r_obuf[6];
    assign oBin8  = r_obuf[7];
    assign oBin9  = r_obuf[8];

endmodule

// File: tb/tb_cell_hist_accum.sv
// tb/tb_cell_hist_accum.sv - directed and scoreboard checks for cell_hist_accum
module tb_cell_hist_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v4  = 1'b0;
    logic        v64 = 1'b0;
    logic        rdy = 1'b1;
    logic [31:0] in_bin [9];
    logic [31:0] o4_bin [9];
    logic [31:0] o64_bin [9];
    logic        o4_valid, o4_ready, o4_sat;
    logic        o64_valid, o64_ready, o64_sat;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cell_hist_accum #(.CELL_PIXELS(4), .BIN_W(32)) dut4 (
        .iClk(clk), .iRst(rst), .iValid(v4), .oReady(o4_ready),
        .iBin1(in_bin[0]), .iBin2(in_bin[1]), .iBin3(in_bin[2]), .iBin4(in_bin[3]),
        .iBin5(in_bin[4]), .iBin6(in_bin[5]), .iBin7(in_bin[6]), .iBin8(in_bin[7]),
        .iBin9(in_bin[8]),
        .oValid(o4_valid), .iReady(rdy),
        .oBin1(o4_bin[0]), .oBin2(o4_bin[1]), .oBin3(o4_bin[2]), .oBin4(o4_bin[3]),
        .oBin5(o4_bin[4]), .oBin6(o4_bin[5]), .oBin7(o4_bin[6]), .oBin8(o4_bin[7]),
        .oBin9(o4_bin[8]), .oSat(o4_sat)
    );

    cell_hist_accum dut64 (
        .iClk(clk), .iRst(rst), .iValid(v64), .oReady(o64_ready),
        .iBin1(in_bin[0]), .iBin2(in_bin[1]), .iBin3(in_bin[2]), .iBin4(in_bin[3]),
        .iBin5(in_bin[4]), .iBin6(in_bin[5]), .iBin7(in_bin[6]), .iBin8(in_bin[7]),
        .iBin9(in_bin[8]),
        .oValid(o64_valid), .iReady(rdy),
        .oBin1(o64_bin[0]), .oBin2(o64_bin[1]), .oBin3(o64_bin[2]), .oBin4(o64_bin[3]),
        .oBin5(o64_bin[4]), .oBin6(o64_bin[5]), .oBin7(o64_bin[6]), .oBin8(o64_bin[7]),
        .oBin9(o64_bin[8]), .oSat(o64_sat)
    );

    typedef struct {
        logic        v;
        logic        r;
        logic [31:0] b1;
        logic [31:0] b3;
        logic [31:0] bo;
        logic        ev;
        logic        er;
        logic [31:0] eb1;
        logic [31:0] eb3;
        logic        es;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic r, logic [31:0] b1, logic [31:0] b3,
                                logic [31:0] bo, logic ev, logic er, logic [31:0] eb1,
                                logic [31:0] eb3, logic es);
        vec_t t;
        t.v = v; t.r = r; t.b1 = b1; t.b3 = b3; t.bo = bo;
        t.ev = ev; t.er = er; t.eb1 = eb1; t.eb3 = eb3; t.es = es;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bins(input logic [31:0] b1, input logic [31:0] b3, input logic [31:0] bo);
        for (int k = 0; k < 9; k++) in_bin[k] = bo;
        in_bin[0] = b1;
        in_bin[2] = b3;
    endtask

    task automatic do_reset();
        rst = 1'b1; v4 = 1'b0; v64 = 1'b0; rdy = 1'b1;
        set_bins(32'h0, 32'h0, 32'h0);
        step();
        rst = 1'b0;
    endtask

    logic [63:0] sb [9];
    int          acc_cnt;
    int          cyc;

    initial begin
        set_bins(32'h0, 32'h0, 32'h0);

        // Reset state
        rst = 1'b1;
        set_bins(32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
        step();
        rst = 1'b0;
        chk("reset_ovalid", o4_valid, 1'b0);
        chk("reset_oready", o4_ready, 1'b1);
        chk("reset_osat", o4_sat, 1'b0);
        for (int k = 0; k < 9; k++) chk($sformatf("reset_obin%0d", k + 1), o4_bin[k], 32'h0);

        // Four votes scaled per bin; all nine sums presented one cycle after the fourth accept
        do_reset();
        for (int n = 0; n < 4; n++) begin
            v4 = 1'b1;
            for (int k = 0; k < 9; k++) in_bin[k] = 32'h0001_0000 * (k + 1);
            step();
        end
        v4 = 1'b0;
        chk("scaled_ovalid", o4_valid, 1'b1);
        chk("scaled_osat", o4_sat, 1'b0);
        for (int k = 0; k < 9; k++) chk($sformatf("scaled_obin%0d", k + 1), o4_bin[k], 32'h0004_0000 * (k + 1));
        step();
        chk("scaled_ovalid_pulse", o4_valid, 1'b0);

        // Table: back-to-back cells, ignored idle inputs, saturation then recovery
        do_reset();
        tbl.push_back(mk(1, 1, 32'h0000_8000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'hDEAD_0000, 32'hDEAD_0000, 32'hDEAD_0000, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h0000_8000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h0000_8000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h0000_8000, 0, 0, 1, 1, 32'h0002_0000, 0, 0));
        tbl.push_back(mk(1, 1, 32'h0000_8000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h0000_8000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h0000_8000, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h0000_8000, 0, 0, 1, 1, 32'h0002_0000, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'hFFFF_0000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'hFFFF_0000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFFF, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0001_0000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0001_0000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0001_0000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0001_0000, 0, 1, 1, 0, 32'h0004_0000, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            v4  = tbl[i].v;
            rdy = tbl[i].r;
            set_bins(tbl[i].b1, tbl[i].b3, tbl[i].bo);
            step();
            chk($sformatf("tbl%0d_ovalid", i), o4_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_oready", i), o4_ready, tbl[i].er);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_obin1", i), o4_bin[0], tbl[i].eb1);
                chk($sformatf("tbl%0d_obin3", i), o4_bin[2], tbl[i].eb3);
                chk($sformatf("tbl%0d_osat", i), o4_sat, tbl[i].es);
            end
        end

        // Full buffer with a stalled consumer pushes the second cell into HOLD
        do_reset();
        rdy = 1'b0;
        for (int n = 0; n < 4; n++) begin
            v4 = 1'b1; set_bins(32'h0001_0000, 0, 0); step();
        end
        chk("hold_first_ovalid", o4_valid, 1'b1);
        chk("hold_first_obin1", o4_bin[0], 32'h0004_0000);
        for (int n = 0; n < 4; n++) begin
            v4 = 1'b1; set_bins(32'h0002_0000, 0, 0); step();
        end
        chk("hold_oready", o4_ready, 1'b0);
        chk("hold_keep_ovalid", o4_valid, 1'b1);
        chk("hold_keep_obin1", o4_bin[0], 32'h0004_0000);
        v4 = 1'b1; set_bins(32'h0100_0000, 0, 0); step();
        chk("hold_stall_oready", o4_ready, 1'b0);
        chk("hold_stall_obin1", o4_bin[0], 32'h0004_0000);
        v4 = 1'b0; rdy = 1'b1; step();
        chk("hold_release_ovalid", o4_valid, 1'b1);
        chk("hold_release_obin1", o4_bin[0], 32'h0008_0000);
        chk("hold_release_oready", o4_ready, 1'b1);
        step();
        chk("hold_drained_ovalid", o4_valid, 1'b0);

        // Reset mid-cell discards the partial sums
        do_reset();
        for (int n = 0; n < 2; n++) begin
            v4 = 1'b1; set_bins(32'h0001_0000, 0, 0); step();
        end
        rst = 1'b1; v4 = 1'b0; step();
        rst = 1'b0;
        chk("midrst_ovalid", o4_valid, 1'b0);
        for (int n = 0; n < 4; n++) begin
            v4 = 1'b1; set_bins(32'h0001_0000, 0, 0); step();
            if (n < 3) chk($sformatf("midrst_early%0d_ovalid", n), o4_valid, 1'b0);
        end
        v4 = 1'b0;
        chk("midrst_ovalid_done", o4_valid, 1'b1);
        chk("midrst_obin1", o4_bin[0], 32'h0004_0000);

        // Default-size cell, random iValid gaps with garbage bins, against a scoreboard
        do_reset();
        for (int k = 0; k < 9; k++) sb[k] = 64'h0;
        acc_cnt = 0;
        cyc = 0;
        while (acc_cnt < 64 && cyc < 2000) begin
            v64 = 1'($urandom_range(0, 1));
            for (int k = 0; k < 9; k++) in_bin[k] = $urandom_range(0, 32'h0003_FFFF);
            if (v64) begin
                for (int k = 0; k < 9; k++) sb[k] = sb[k] + 64'(in_bin[k]);
                acc_cnt++;
            end
            step();
            cyc++;
        end
        v64 = 1'b0;
        chk("rand_votes_done", 32'(acc_cnt), 32'd64);
        chk("rand_ovalid", o64_valid, 1'b1);
        chk("rand_osat", o64_sat, 1'b0);
        for (int k = 0; k < 9; k++) begin
            logic [31:0] exp_v;
            exp_v = (sb[k] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sb[k][31:0];
            chk($sformatf("rand_obin%0d", k + 1), o64_bin[k], exp_v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cell_hist_accum.md
CELL_HIST_ACCUM -- requirements
Module: cell_hist_accum

Interface
REQ-001 Parameter CELL_PIXELS, default 64, SHALL set the number of per-pixel votes summed into one cell histogram (legal range 2..256).
REQ-002 Parameter BIN_W, default 32, SHALL set the width of every input bin and accumulator.
REQ-003 iClk  input  1  sole clock; all logic SHALL be rising-edge triggered on iClk.
REQ-004 iRst  input  1  synchronous, active-high reset.
REQ-005 iValid  input  1  the 9 input bins are valid this cycle.
REQ-006 oReady  output  1  the block accepts a pixel vote this cycle.
REQ-007 iBin1..iBin9  input  BIN_W each  per-pixel bin votes, unsigned fixed-point Q16.16, bins 0..160 deg in 20 deg steps.
REQ-008 oValid  output  1  the cell histogram outputs are valid.
REQ-009 iReady  input  1  the downstream consumer accepts the cell histogram.
REQ-010 oBin1..oBin9  output  BIN_W each  cell histogram sums, Q16.16.
REQ-011 oSat  output  1  at least one bin of the presented cell saturated.

Function
REQ-012 A pixel vote SHALL be accepted on a cycle where iValid and oReady are both 1; each iBinK SHALL be added to accumulator K.
REQ-013 Addition SHALL be unsigned and saturating at 2^BIN_W-1; any saturating add SHALL set a per-cell saturation flag.
REQ-014 A pixel counter SHALL count accepted votes from 0 to CELL_PIXELS-1 and wrap to 0 on the last vote of a cell.
REQ-015 FSM states: ACCUM (oReady=1) and HOLD (oReady=0).
REQ-016 On acceptance of the last vote of a cell, the final sums (including that vote) and the saturation flag SHALL be transferred to the output buffer on the same edge if the buffer is empty or is being emptied in that cycle (oValid&iReady); accumulators, flag and counter SHALL clear on that edge and the FSM SHALL stay in ACCUM.
REQ-017 If the buffer is full and not being emptied, the final sums SHALL stay in the accumulators and the FSM SHALL enter HOLD.
REQ-018 In HOLD, on the first cycle with iReady=1 the accumulator contents SHALL move to the output buffer, accumulators SHALL clear, and the FSM SHALL return to ACCUM on the next edge.
REQ-019 Latency: last vote accepted at edge t -> oValid=1 and oBin1..9 valid after edge t (cycle t+1) when the buffer is free.
REQ-020 oValid SHALL remain 1 and oBin1..9, oSat SHALL be stable until the cycle with oValid&iReady; oValid SHALL then fall unless a new cell is loaded on the same edge.
REQ-021 Sustained throughput SHALL be one vote per cycle with iReady tied to 1; no bubble at cell boundaries.
REQ-022 iBin inputs SHALL be ignored when iValid=0 or oReady=0.

Reset
REQ-023 On iRst=1 at an edge: FSM=ACCUM, counter=0, accumulators=0, saturation flag=0, oValid=0, oBin1..9=0, oSat=0; oReady SHALL read 1 from the following cycle.
REQ-024 iRst asserted mid-cell or during HOLD SHALL discard the partial cell and any buffered histogram; no output SHALL be produced for them.

Structure
REQ-025 A shared package SHALL hold NUM_BINS=9, the Q16.16 format constant (FRAC_BITS=16), and the FSM state encoding.
REQ-026 One sub-module, sat_add, SHALL implement a BIN_W-bit unsigned saturating adder with a saturation flag output, instantiated nine times.

Verification
REQ-027 CELL_PIXELS=4, iReady=1, 4 votes each iBinK=0x00010000*K -> one cycle after the 4th accept, oBinK=0x00040000*K, oSat=0, oValid high 1 cycle.
REQ-028 Back-to-back 8 votes, iReady=1, iBin1=0x00008000 others 0 -> two cells, each oBin1=0x00020000, no oReady deassertion.
REQ-029 iReady=0 with buffer full, second cell completes -> oReady=0 (HOLD), first cell held stable; raise iReady -> second cell presented next cycle, oReady=1 again.
REQ-030 iBin3=0xFFFF0000 for 2 votes -> oBin3=0xFFFFFFFF, oSat=1; next cell with small values -> oSat=0.
REQ-031 iRst pulsed after 2 of 4 votes, then 4 votes of 0x00010000 -> oBin1=0x00040000 (partial cell discarded).
REQ-032 iValid toggled randomly, 64 votes at default parameter -> sums equal scoreboard reference; iBin changes with iValid=0 have no effect.
